result_argmax: RTL and testbench
================================

Name: result_argmax

Overview:
- Post-processing stage directly downstream of the CNN layer sequencer.
- When the final fully-connected layer completes, it reads the num_class signed fixed-point scores from BRAM starting at result_addr.
- Returns the index and value of the maximum score as the classification result, then pulses done.
- The sequencer pulses start on its final-layer completion and raises cnn_finish on done.

Parameters:
- width, 8, score word width (signed, two's complement, fixed point)
- memaddrbit, 14, BRAM address width
- num_class, 10, number of scores to scan (1..255)
- result_addr, 7101, BRAM address of score 0 (final-layer output base)
- read_latency, 1, BRAM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a scan
- busy  out  1  high while a scan is in progress (not IDLE)
- done  out  1  one-cycle pulse when the result is valid
- mem_rd_en  out  1  BRAM read enable
- memaddr  out  memaddrbit  BRAM read address
- mem_out  in  width  BRAM read data, valid read_latency cycles after the address
- class_idx  out  8  index of the maximum score
- max_val  out  width  maximum score
- valid  out  1  result held valid from done until the next accepted start or reset

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: busy, done, mem_rd_en, memaddr, class_idx, max_val, valid.
  - Internal counters and pipeline valid bits are cleared.
- Reset mid-scan: the scan is abandoned, no done is produced, and a new start is required.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 sampled at edge E0 moves to READ.
  - On that same edge: valid cleared, issue counter set to 0, best_val set to the most negative value (1 followed by zeros), best_idx set to 0.
- READ:
  - Lasts exactly num_class cycles.
  - mem_rd_en=1 and memaddr=result_addr+issue_cnt; issue_cnt increments each cycle.
  - Moves to DRAIN after issue_cnt = num_class-1.
- DRAIN:
  - Lasts read_latency cycles, mem_rd_en=0.
  - Moves to DONE.
- DONE:
  - Lasts one cycle: done=1, valid=1; class_idx and max_val are already registered.
  - Moves to IDLE.
- memaddr is 0 whenever not in READ.
- Data alignment:
  - A read_latency-deep shift register carries a valid bit and a receive index alongside each issued read.
  - The compare uses mem_out only when the delayed valid bit is 1.
- Compare:
  - Signed: if mem_out > best_val (strict), then best_val <= mem_out and best_idx <= receive index.
  - Ties keep the lower index.
  - All-equal or all-minimum inputs give index 0.
- class_idx and max_val update only on the DONE edge; they are stable between scans.
- Latency: done is high in cycle num_class+read_latency+1 after E0 (12 for the defaults).
- start while busy is ignored; it is neither queued nor able to restart the scan.
- start coincident with the DONE cycle is ignored. start in the cycle after DONE (IDLE) is accepted.
- Address arithmetic is memaddrbit wide and wraps modulo 2^memaddrbit. The integrator must keep the range in bounds.

Optional Feature:
- Macro: ARGMAX_TOP2_EN
- When defined:
  - Adds outputs second_idx (8 bits) and second_val (width bits) with the same timing as class_idx/max_val.
  - Tracking rule per compare:
    - If new > best: second <= best, then best <= new.
    - Else if new > second: second <= new.
  - second_val resets to 0 and is initialised to the most negative value at scan start.
  - For num_class=1, second_idx=0 and second_val is the most negative value.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Scores 3,-5,20,7,1,0,-1,19,2,4 at 7101..7110, start pulse:
  - Addresses 7101..7110 on consecutive cycles with mem_rd_en=1.
  - done in cycle 12; class_idx=2, max_val=20, valid=1.
- Scores all -128:
  - class_idx=0, max_val=-128.
  - Tie case with 9 at index 3 and index 6, max elsewhere lower: class_idx=3.
- Negative maximum (all scores in -90..-10, -10 at index 9):
  - class_idx=9 (checks the signed compare).
- start pulses at cycles 2 and 5 after the first start:
  - Exactly one done at cycle 12, and the address sequence is uninterrupted.
  - A start in the cycle after done launches a second scan.
- rst=0 at cycle 6 of a scan:
  - All outputs 0 immediately and no done.
  - After release, a new start gives a correct result.
- ARGMAX_TOP2_EN defined, first vector:
  - class_idx=2/20, second_idx=7/19.
  - Repeat with read_latency=3: done in cycle 14.

Source files
------------

// File: rtl/result_argmax.sv
// Argmax over num_class signed scores read back from BRAM after the final CNN layer.
// Define ARGMAX_TOP2_EN to also report the runner-up score (second_idx/second_val).
module result_argmax #(
    parameter int width        = 8,
    parameter int memaddrbit   = 14,
    parameter int num_class    = 10,
    parameter int result_addr  = 7101,
    parameter int read_latency = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [memaddrbit-1:0] memaddr,
    input  logic [width-1:0]      mem_out,
    output logic [7:0]            class_idx,
    output logic [width-1:0]      max_val,
`ifdef ARGMAX_TOP2_EN
    output logic [7:0]            second_idx,
    output logic [width-1:0]      second_val,
`endif
    output logic                  valid
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};
    localparam logic [7:0]       LAST_IDX = 8'(num_class - 1);
    localparam logic [1:0]       LAST_LAT = 2'(read_latency - 1);

    state_e                        state_q, state_d;
    logic [7:0]                    issue_cnt_q, issue_cnt_d;
    logic [1:0]                    lat_cnt_q, lat_cnt_d;
    logic [read_latency-1:0]       pipe_vld_q, pipe_vld_d;
    logic [read_latency-1:0][7:0]  pipe_idx_q, pipe_idx_d;
    logic [width-1:0]              best_val_q, best_val_d;
    logic [7:0]                    best_idx_q, best_idx_d;
    logic [7:0]                    class_idx_q, class_idx_d;
    logic [width-1:0]              max_val_q, max_val_d;
    logic                          valid_q, valid_d;
    logic [7:0]                    rx_idx;
`ifdef ARGMAX_TOP2_EN
    logic [width-1:0]              sec_val_q, sec_val_d;
    logic [7:0]                    sec_idx_q, sec_idx_d;
    logic [7:0]                    second_idx_q, second_idx_d;
    logic [width-1:0]              second_val_q, second_val_d;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_idx_d  = pipe_idx_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        valid_d     = valid_q;
        rx_idx      = pipe_idx_q[read_latency-1];
`ifdef ARGMAX_TOP2_EN
        sec_val_d    = sec_val_q;
        sec_idx_d    = sec_idx_q;
        second_idx_d = second_idx_q;
        second_val_d = second_val_q;
`endif
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_rd_en = 1'b0;
        memaddr   = '0;

        // Valid/index tags travel alongside each read so the compare sees aligned data.
        pipe_vld_d[0] = (state_q == READ);
        pipe_idx_d[0] = issue_cnt_q;
        for (int i = 1; i < read_latency; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        // Strict greater-than keeps the lowest index on ties.
        if (pipe_vld_q[read_latency-1]) begin
            if ($signed(mem_out) > $signed(best_val_q)) begin
`ifdef ARGMAX_TOP2_EN
                sec_val_d = best_val_q;
                sec_idx_d = best_idx_q;
`endif
                best_val_d = mem_out;
                best_idx_d = rx_idx;
            end
`ifdef ARGMAX_TOP2_EN
            else if ($signed(mem_out) > $signed(sec_val_q)) begin
                sec_val_d = mem_out;
                sec_idx_d = rx_idx;
            end
`else
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    valid_d     = 1'b0;
                    issue_cnt_d = '0;
                    best_val_d  = MOST_NEG;
                    best_idx_d  = '0;
`ifdef ARGMAX_TOP2_EN
                    sec_val_d = MOST_NEG;
                    sec_idx_d = '0;
`endif
                end
            end
            READ: begin
                mem_rd_en   = 1'b1;
                memaddr     = memaddrbit'(result_addr) + memaddrbit'(issue_cnt_q);
                issue_cnt_d = issue_cnt_q + 8'd1;
                if (issue_cnt_q == LAST_IDX) begin
                    state_d   = DRAIN;
                    lat_cnt_d = '0;
                end
            end
            DRAIN: begin
                // The last compare lands on this edge, so publish the next-state best.
                if (lat_cnt_q == LAST_LAT) begin
                    state_d     = DONE;
                    class_idx_d = best_idx_d;
                    max_val_d   = best_val_d;
                    valid_d     = 1'b1;
`ifdef ARGMAX_TOP2_EN
                    second_idx_d = sec_idx_d;
                    second_val_d = sec_val_d;
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            lat_cnt_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_idx_q  <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            valid_q     <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_val_q    <= '0;
            sec_idx_q    <= '0;
            second_idx_q <= '0;
            second_val_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_idx_q  <= pipe_idx_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            valid_q     <= valid_d;
`ifdef ARGMAX_TOP2_EN
            sec_val_q    <= sec_val_d;
            sec_idx_q    <= sec_idx_d;
            second_idx_q <= second_idx_d;
            second_val_q <= second_val_d;
`endif
        end
    end

    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign valid     = valid_q;
`ifdef ARGMAX_TOP2_EN
    assign second_idx = second_idx_q;
    assign second_val = second_val_q;
`endif

endmodule

// File: tb/tb_result_argmax.sv
// Scoreboard bench for result_argmax: BRAM model, random and directed score vectors.
module tb_result_argmax;

    localparam int W    = 8;
    localparam int AB   = 14;
    localparam int N    = 10;
    localparam int BASE = 7101;
    localparam int MNEG = -(2 ** (W - 1));
    parameter  int RL   = 1;

    logic          clk, rst, start;
    logic          busy, done, mem_rd_en, valid;
    logic [AB-1:0] memaddr;
    logic [W-1:0]  mem_out;
    logic [7:0]    class_idx;
    logic [W-1:0]  max_val;
`ifdef ARGMAX_TOP2_EN
    logic [7:0]    second_idx;
    logic [W-1:0]  second_val;
`endif

    result_argmax #(
        .width(W), .memaddrbit(AB), .num_class(N), .result_addr(BASE), .read_latency(RL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .memaddr(memaddr), .mem_out(mem_out),
        .class_idx(class_idx), .max_val(max_val),
`ifdef ARGMAX_TOP2_EN
        .second_idx(second_idx), .second_val(second_val),
`endif
        .valid(valid)
    );

    typedef struct {
        int idx;
        int val;
        int sidx;
        int sval;
        int done_cyc;
    } exp_t;

    logic [W-1:0] mem [2 ** AB];
    logic [W-1:0] rd_pipe [RL];
    exp_t         sb_q [$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    int           rd_k     = 0;
    int           e0, e1;
    int           vec1 [N] = '{3, -5, 20, 7, 1, 0, -1, 19, 2, 4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous BRAM with RL cycles of read latency.
    always @(posedge clk) begin
        rd_pipe[0] <= mem[memaddr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_out = rd_pipe[RL-1];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: max value with its first index; runner-up is the best of the rest,
    // reported at index 0 when nothing beats the most negative value.
    function automatic exp_t model(input int start_edge);
        exp_t r;
        int   v [N];
        int   mx;
        for (int i = 0; i < N; i++) v[i] = $signed(mem[(BASE + i) % (2 ** AB)]);
        mx = MNEG;
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        r.val = mx;
        r.idx = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i] == mx) r.idx = i;
        r.sval = MNEG;
        foreach (v[i]) if (i != r.idx && v[i] > r.sval) r.sval = v[i];
        r.sidx = 0;
        if (r.sval > MNEG)
            for (int i = N - 1; i >= 0; i--) if (i != r.idx && v[i] == r.sval) r.sidx = i;
        r.done_cyc = start_edge + N + RL;
        return r;
    endfunction

    // Monitor: address stream every cycle, result on every done.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            check("rd_addr", int'(memaddr), (BASE + rd_k) % (2 ** AB));
            rd_k++;
        end else begin
            check("idle_addr", int'(memaddr), 0);
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("class_idx", int'(class_idx), mon_e.idx);
                check("max_val", int'($signed(max_val)), mon_e.val);
                check("valid_at_done", int'(valid), 1);
                check("done_cycle", cyc, mon_e.done_cyc);
                check("reads_per_scan", rd_k, N);
`ifdef ARGMAX_TOP2_EN
                check("second_idx", int'(second_idx), mon_e.sidx);
                check("second_val", int'($signed(second_val)), mon_e.sval);
`endif
            end
            rd_k = 0;
        end else if (!busy) begin
            rd_k = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_start(input bit push, output int edge_cyc);
        start = 1'b1;
        edge_cyc = cyc + 1;
        if (push) sb_q.push_back(model(edge_cyc));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        int g = 0;
        while (cyc < c && g < 1000) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || sb_q.size() != 0) && g < 200) begin
            tick();
            g++;
        end
        check("scan_completed", sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_rd_en"}, int'(mem_rd_en), 0);
        check({tag, "_addr"}, int'(memaddr), 0);
        check({tag, "_idx"}, int'(class_idx), 0);
        check({tag, "_val"}, int'(max_val), 0);
        check({tag, "_valid"}, int'(valid), 0);
    endtask

    task automatic load_vec1();
        for (int i = 0; i < N; i++) mem[BASE + i] = W'(vec1[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2 ** AB; i++) mem[i] = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Reference vector with known answer.
        load_vec1();
        issue_start(1'b1, e0);
        wait_idle();
        check("vec1_idx", int'(class_idx), 2);
        check("vec1_val", int'($signed(max_val)), 20);
`ifdef ARGMAX_TOP2_EN
        check("vec1_second_idx", int'(second_idx), 7);
        check("vec1_second_val", int'($signed(second_val)), 19);
`endif
        repeat (3) tick();
        check("valid_held", int'(valid), 1);
        check("idx_held", int'(class_idx), 2);

        // All most-negative: index 0; result from the previous scan holds until DONE.
        for (int i = 0; i < N; i++) mem[BASE + i] = W'(MNEG);
        issue_start(1'b1, e0);
        check("valid_cleared_on_start", int'(valid), 0);
        check("idx_stable_in_scan", int'(class_idx), 2);
        wait_idle();
        check("allneg_idx", int'(class_idx), 0);
        check("allneg_val", int'($signed(max_val)), MNEG);

        // Tie at indices 3 and 6.
        for (int i = 0; i < N; i++) mem[BASE + i] = W'($urandom_range(136, 0) - 128);
        mem[BASE + 3] = 8'd9;
        mem[BASE + 6] = 8'd9;
        issue_start(1'b1, e0);
        wait_idle();
        check("tie_idx", int'(class_idx), 3);

        // Negative maximum at the last index.
        for (int i = 0; i < N; i++) mem[BASE + i] = W'(-int'($urandom_range(90, 11)));
        mem[BASE + 9] = W'(-10);
        issue_start(1'b1, e0);
        wait_idle();
        check("negmax_idx", int'(class_idx), 9);
        check("negmax_val", int'($signed(max_val)), -10);

        // Starts while busy and during DONE are ignored; start right after DONE launches.
        for (int i = 0; i < N; i++) mem[BASE + i] = W'($urandom);
        issue_start(1'b1, e0);
        wait_cyc(e0 + 1);
        start = 1'b1; tick(); start = 1'b0;
        wait_cyc(e0 + 4);
        start = 1'b1; tick(); start = 1'b0;
        wait_cyc(e0 + N + RL);
        check("done_cycle_seen", int'(done), 1);
        start = 1'b1;
        e1 = cyc + 2;
        sb_q.push_back(model(e1));
        tick();
        tick();
        start = 1'b0;
        wait_idle();

        // Reset in cycle 6 of a scan abandons it.
        load_vec1();
        issue_start(1'b0, e0);
        wait_cyc(e0 + 5);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("no_done_after_reset", int'(valid), 0);
        issue_start(1'b1, e0);
        wait_idle();
        check("post_reset_idx", int'(class_idx), 2);

        // Randomized scans with stray starts and random gaps.
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(3, 0) == 0)
                for (int i = 0; i < N; i++) mem[BASE + i] = W'($urandom_range(3, 0) * 40 - 60);
            else
                for (int i = 0; i < N; i++) mem[BASE + i] = W'($urandom);
            issue_start(1'b1, e0);
            if ($urandom_range(1, 0) == 1) begin
                wait_cyc(e0 + int'($urandom_range(N + RL, 1)));
                start = 1'b1; tick(); start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(3, 0)) tick();
        end

        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
